ddc_acc_scheduler: RTL

Output scheduler between the per-channel I/Q accumulators and the single DDC AXI-Stream output. It captures one accumulated frame (all N_CH channels, latched together on the accumulator valid strobe) and emits it as N_CH consecutive beats, one channel per beat, fully honouring m_axis_tready backpressure. A one-frame pending bank absorbs a second frame while the first drains. A frame arriving with both banks occupied is dropped and counted, never partially emitted.

---
 rtl/ddc_oct_pkg.sv | 27 ++
 rtl/ddc_acc_scheduler_if.sv | 31 +++
 rtl/ddc_frame_bank.sv | 34 +++
 rtl/ddc_acc_scheduler.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ddc_oct_pkg.sv
// Shared DDC definitions: accumulator widths, scheduler FSM encoding and
// helpers for channel-index width and {Q,I} slice placement inside a frame.
package ddc_oct_pkg;

  localparam int ACC_WIDTH = 48;
  localparam int DDC_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_e;

  // Channel index width; never below one bit so a single-channel build still has a tuser.
  function automatic int calc_ch_w(input int n_ch);
    if (n_ch > 1) begin
      return $clog2(n_ch);
    end else begin
      return 1;
    end
  endfunction

  // LSB of channel ch inside a packed frame; each channel is {Q,I}, Q in the upper half.
  function automatic int chan_lsb(input int ch, input int acc_w);
    return 2 * acc_w * ch;
  endfunction

endpackage

// File: rtl/ddc_acc_scheduler_if.sv
// AXI-Stream output bundle of the DDC accumulator scheduler.
interface ddc_acc_scheduler_if #(
  parameter int N_CH      = 4,
  parameter int ACC_WIDTH = 48
) ();

  localparam int CH_W = ddc_oct_pkg::calc_ch_w(N_CH);

  logic [2*ACC_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [CH_W-1:0]        tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/ddc_frame_bank.sv
// One frame-wide holding register with a full flag; load takes priority over
// clear so a bank can be emptied and refilled in the same cycle.
module ddc_frame_bank #(
  parameter int FRAME_W = 384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [FRAME_W-1:0] din,
  output logic [FRAME_W-1:0] dout,
  output logic               full
);

  logic [FRAME_W-1:0] data_r;
  logic               full_r;

  // Frame storage and occupancy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {FRAME_W{1'b0}};
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= din;
      full_r <= 1'b1;
    end else if (clear) begin
      full_r <= 1'b0;
    end
  end

  assign dout = data_r;
  assign full = full_r;

endmodule

// File: rtl/ddc_acc_scheduler.sv
// Serialises one accumulated N_CH-channel frame onto AXI-Stream, one channel per
// beat, with a one-frame pending bank and a saturating dropped-frame counter.
module ddc_acc_scheduler #(
  parameter int N_CH           = 4,
  parameter int ACC_WIDTH      = ddc_oct_pkg::ACC_WIDTH,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          acc_valid,
  input  logic [N_CH*2*ACC_WIDTH-1:0]   acc_data,
  ddc_acc_scheduler_if.master           m_axis,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt,
  output logic                          overflow,
  input  logic                          clear_stat,
  output logic                          busy
);

  import ddc_oct_pkg::*;

  localparam int BEAT_W  = 2 * ACC_WIDTH;
  localparam int FRAME_W = N_CH * BEAT_W;
  localparam int CH_W    = calc_ch_w(N_CH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

  sched_state_e        state_r, state_nxt_s;
  logic [CH_W-1:0]     ch_r, ch_nxt_s;
  logic                act_load_s, act_clear_s, act_full_s;
  logic                pend_load_s, pend_clear_s, pend_full_s, pend_full_nxt_s;
  logic                pend_to_act_s, drop_s;
  logic                xfer_s, last_xfer_s;
  logic [FRAME_W-1:0]  act_din_s, act_dout_s, pend_dout_s, act_src_s;
  logic [BEAT_W-1:0]   beats_s [N_CH];
  logic [BEAT_W-1:0]   tdata_r;
  logic [CH_W-1:0]     tuser_r;
  logic                tlast_r;
  logic                busy_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;
  logic                overflow_r;

  // The active bank's full flag is the beat-valid: it is set exactly while a frame drains.
  assign xfer_s          = act_full_s & m_axis.tready;
  assign last_xfer_s     = xfer_s & (ch_r == CH_LAST);
  assign act_din_s       = pend_to_act_s ? pend_dout_s : acc_data;
  assign act_src_s       = act_load_s ? act_din_s : act_dout_s;
  assign pend_full_nxt_s = pend_load_s | (pend_full_s & ~pend_clear_s);

  ddc_frame_bank #(.FRAME_W(FRAME_W)) u_act_bank (
    .clk   (clk),
    .rst   (rst),
    .load  (act_load_s),
    .clear (act_clear_s),
    .din   (act_din_s),
    .dout  (act_dout_s),
    .full  (act_full_s)
  );

  ddc_frame_bank #(.FRAME_W(FRAME_W)) u_pend_bank (
    .clk   (clk),
    .rst   (rst),
    .load  (pend_load_s),
    .clear (pend_clear_s),
    .din   (acc_data),
    .dout  (pend_dout_s),
    .full  (pend_full_s)
  );

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_beat
    assign beats_s[gi] = act_src_s[chan_lsb(gi, ACC_WIDTH) +: BEAT_W];
  end

  // Next-state, channel counter and bank-control decode.
  always_comb begin
    state_nxt_s   = state_r;
    ch_nxt_s      = ch_r;
    act_load_s    = 1'b0;
    act_clear_s   = 1'b0;
    pend_load_s   = 1'b0;
    pend_clear_s  = 1'b0;
    pend_to_act_s = 1'b0;
    drop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ch_nxt_s = {CH_W{1'b0}};
        if (acc_valid) begin
          act_load_s  = 1'b1;
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_xfer_s) begin
          ch_nxt_s = {CH_W{1'b0}};
          if (pend_full_s) begin
            // Promote pending; a coincident new frame refills pending, so nothing drops.
            pend_to_act_s = 1'b1;
            act_load_s    = 1'b1;
            if (acc_valid) begin
              pend_load_s = 1'b1;
            end else begin
              pend_clear_s = 1'b1;
            end
          end else if (acc_valid) begin
            act_load_s = 1'b1;
          end else begin
            act_clear_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          if (xfer_s) begin
            ch_nxt_s = ch_r + CH_W'(1);
          end else begin
            ch_nxt_s = ch_r;
          end
          if (acc_valid) begin
            if (pend_full_s) begin
              drop_s = 1'b1;
            end else begin
              pend_load_s = 1'b1;
            end
          end else begin
            drop_s = 1'b0;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ch_nxt_s    = {CH_W{1'b0}};
        act_clear_s = 1'b1;
      end
    endcase
  end

  // State, channel and registered beat outputs derived from next-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ch_r    <= {CH_W{1'b0}};
      tdata_r <= {BEAT_W{1'b0}};
      tuser_r <= {CH_W{1'b0}};
      tlast_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ch_r    <= ch_nxt_s;
      tdata_r <= beats_s[ch_nxt_s];
      tuser_r <= ch_nxt_s;
      tlast_r <= (state_nxt_s == ST_SEND) && (ch_nxt_s == CH_LAST);
      busy_r  <= (state_nxt_s == ST_SEND) | pend_full_nxt_s;
    end
  end

  // Drop statistics; a drop in the same cycle as clear_stat leaves a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clear_stat) begin
        drop_cnt_r <= DROP_CNT_WIDTH'(1);
      end else if (drop_cnt_r != {DROP_CNT_WIDTH{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + DROP_CNT_WIDTH'(1);
      end
    end else if (clear_stat) begin
      drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end
  end

  assign m_axis.tvalid = act_full_s;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tuser  = tuser_r;
  assign m_axis.tlast  = tlast_r;
  assign drop_cnt      = drop_cnt_r;
  assign overflow      = overflow_r;
  assign busy          = busy_r;

endmodule
